// File: rtl/kvadd_ctrl_pkg.sv
// Shared types and helpers for the kvadd kernel control sequencer.
package kvadd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ctrl_state_t;

  localparam int unsigned MODE_HS    = 0;
  localparam int unsigned MODE_CHAIN = 1;

  // Width of the channel mask; a zero channel count still needs one bit.
  function automatic int unsigned ch_mask_w(input int unsigned num_ch);
    return (num_ch == 0) ? 32'd1 : num_ch;
  endfunction

endpackage

// File: rtl/kvadd_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module kvadd_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             ap_clk,
  input  logic             areset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/kvadd_kernel_ctrl.sv
// Kernel start/done sequencer: fans a start out to the channel engines and
// aggregates their done pulses, in ap_ctrl_hs or ap_ctrl_chain style.
module kvadd_kernel_ctrl
  import kvadd_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned CTRL_MODE = 0,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              ap_clk,
  input  logic              areset,
  input  logic              ap_start,
  input  logic              ap_continue,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] ch_done,
  output logic              ap_idle,
  output logic              ap_done,
  output logic              ap_ready,
  output logic [NUM_CH-1:0] ch_start,
  output logic [CNT_W-1:0]  busy_cycles
);

  localparam int unsigned MASK_W = ch_mask_w(NUM_CH);
  localparam bit          CHAIN  = (CTRL_MODE == MODE_CHAIN);

  ctrl_state_t       state_q, state_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [MASK_W-1:0] done_q, done_d;
  logic              pend_q, pend_d;
  logic              ap_start_r;
  logic              start_ev;
  logic              launch;
  logic              done_pulse;
  logic              hold_done;
  logic              cnt_clr;
  logic              cnt_en;
  logic              ap_idle_d;
  logic              ap_done_d;
  logic              ap_ready_d;
  logic [NUM_CH-1:0] ch_start_d;

  // Next-state, datapath and output decode
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    done_d     = done_q;
    pend_d     = pend_q;
    ch_start_d = '0;
    launch     = 1'b0;
    done_pulse = 1'b0;
    hold_done  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    start_ev   = ap_start & ~ap_start_r;

    case (state_q)
      IDLE: begin
        if (start_ev) begin
          launch = 1'b1;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        done_d = done_q | (ch_done & mask_q);
        if (CHAIN && start_ev) begin
          pend_d = 1'b1;
        end
        // Pulse only on the edge that completes the mask, not on a mask that was empty from launch
        if (done_d == mask_q) begin
          state_d = CHAIN ? HOLD : IDLE;
          if (done_q != mask_q) begin
            done_pulse = 1'b1;
          end
        end
      end
      HOLD: begin
        if (start_ev) begin
          pend_d = 1'b1;
        end
        if (ap_continue) begin
          if (pend_d) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch) begin
      state_d    = RUN;
      mask_d     = ch_enable;
      done_d     = '0;
      pend_d     = 1'b0;
      ch_start_d = ch_enable;
      cnt_clr    = 1'b1;
      if (ch_enable == '0) begin
        done_pulse = 1'b1;
      end
    end

    ap_ready_d = done_pulse;
    ap_done_d  = CHAIN ? hold_done : done_pulse;
    ap_idle_d  = (state_d == IDLE) && !ap_done_d;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q    <= IDLE;
      ap_start_r <= 1'b0;
      mask_q     <= '0;
      done_q     <= '0;
      pend_q     <= 1'b0;
      ap_idle    <= 1'b1;
      ap_done    <= 1'b0;
      ap_ready   <= 1'b0;
      ch_start   <= '0;
    end else begin
      state_q    <= state_d;
      ap_start_r <= ap_start;
      mask_q     <= mask_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      ap_idle    <= ap_idle_d;
      ap_done    <= ap_done_d;
      ap_ready   <= ap_ready_d;
      ch_start   <= ch_start_d;
    end
  end

  kvadd_sat_counter #(
    .CNT_W (CNT_W)
  ) u_busy_cnt (
    .ap_clk (ap_clk),
    .areset (areset),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .count  (busy_cycles)
  );

endmodule

// File: tb/tb_kvadd_kernel_ctrl.sv
// Self-checking bench: one ap_ctrl_hs and one ap_ctrl_chain instance driven by
// random task schedules, with expectations derived from per-task timing arithmetic.
module tb_kvadd_kernel_ctrl;

  typedef int dly_t [3];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       hs_rst, hs_start, hs_cont;
  logic [2:0] hs_en, hs_done;
  logic       hs_idle, hs_apdone, hs_ready;
  logic [2:0] hs_chs;
  logic [7:0] hs_busy;

  logic        cs_rst, cs_start, cs_cont;
  logic [2:0]  cs_en, cs_done;
  logic        cs_idle, cs_apdone, cs_ready;
  logic [2:0]  cs_chs;
  logic [15:0] cs_busy;

  kvadd_kernel_ctrl #(.NUM_CH(3), .CTRL_MODE(0), .CNT_W(8)) u_hs (
    .ap_clk(clk), .areset(hs_rst), .ap_start(hs_start), .ap_continue(hs_cont),
    .ch_enable(hs_en), .ch_done(hs_done), .ap_idle(hs_idle), .ap_done(hs_apdone),
    .ap_ready(hs_ready), .ch_start(hs_chs), .busy_cycles(hs_busy)
  );

  kvadd_kernel_ctrl #(.NUM_CH(3), .CTRL_MODE(1), .CNT_W(16)) u_cs (
    .ap_clk(clk), .areset(cs_rst), .ap_start(cs_start), .ap_continue(cs_cont),
    .ch_enable(cs_en), .ch_done(cs_done), .ap_idle(cs_idle), .ap_done(cs_apdone),
    .ap_ready(cs_ready), .ch_start(cs_chs), .busy_cycles(cs_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latest required done offset of a task; 0 for an empty mask.
  function automatic int dmax_of(input logic [2:0] m, input dly_t d);
    int r;
    r = 0;
    for (int i = 0; i < 3; i++) if (m[i] && d[i] > r) r = d[i];
    return r;
  endfunction

  // Done pattern at offset o: first pulse of an enabled channel exactly at d[i],
  // random repeats afterwards, random noise on disabled channels and outside RUN.
  function automatic logic [2:0] done_vec(input logic [2:0] m, input dly_t d,
                                          input int dmax, input int o);
    logic [2:0] v;
    v = 3'($urandom);
    if (o <= dmax) begin
      for (int i = 0; i < 3; i++) begin
        if (m[i]) begin
          if (o < d[i]) v[i] = 1'b0;
          else if (o == d[i]) v[i] = 1'b1;
        end
      end
    end
    return v;
  endfunction

  task automatic hs_task(input logic [2:0] m, input dly_t d, input bit restart);
    int dmax, p, bexp;
    dmax = dmax_of(m, d);
    p    = (m == 3'b000) ? 1 : dmax + 1;
    bexp = (m == 3'b000) ? 1 : ((dmax > 255) ? 255 : dmax);
    hs_en = m; hs_start = 1'b1; hs_done = 3'b000;
    for (int o = 1; o <= p + 1; o++) begin
      tick();
      chk("hs_ch_start", hs_chs, (o == 1) ? m : 3'b000);
      chk("hs_ap_done", hs_apdone, o == p);
      chk("hs_ap_ready", hs_ready, o == p);
      chk("hs_ap_idle", hs_idle, o > p);
      if (o == 1) chk("hs_busy_clr", hs_busy, 0);
      if (o == p + 1) chk("hs_busy", hs_busy, bexp);
      hs_start = restart && (dmax >= 2) && (o == 2);
      hs_cont  = 1'($urandom);
      hs_en    = 3'($urandom);
      hs_done  = done_vec(m, d, dmax, o);
    end
    hs_start = 1'b0; hs_done = 3'b000;
  endtask

  task automatic cs_task(input logic [2:0] m1, input dly_t d1, input int gap, input int s2,
                         input logic [2:0] m2, input dly_t d2, input bit third);
    int k1, k2, c, c2, last;
    k1   = dmax_of(m1, d1);
    c    = k1 + 2 + gap;
    k2   = c + dmax_of(m2, d2);
    c2   = k2 + 2 + gap;
    last = (s2 != 0) ? c2 : c;
    cs_en = m1; cs_start = 1'b1; cs_cont = 1'b0; cs_done = 3'b000;
    for (int o = 1; o <= last + 2; o++) begin
      tick();
      chk("cs_ch_start", cs_chs, (o == 1) ? m1 : ((s2 != 0 && o == c + 1) ? m2 : 3'b000));
      chk("cs_ap_ready", cs_ready, (o == k1 + 1) || (s2 != 0 && o == k2 + 1));
      chk("cs_ap_done", cs_apdone, (o >= k1 + 2 && o <= c) || (s2 != 0 && o >= k2 + 2 && o <= c2));
      chk("cs_ap_idle", cs_idle, o > last);
      if (o == c) chk("cs_busy1", cs_busy, k1);
      if (s2 != 0 && o == c + 1) chk("cs_busy_clr", cs_busy, 0);
      if (s2 != 0 && o == c2) chk("cs_busy2", cs_busy, k2 - c);
      cs_start = (s2 == 1 && o == 2) || (third && o == 4) || (s2 == 2 && o == c);
      cs_cont  = (o == c) || (s2 != 0 && o == c2);
      cs_en    = (s2 != 0 && o == c) ? m2 : 3'($urandom);
      if (o < c) cs_done = done_vec(m1, d1, k1, o);
      else if (s2 != 0) cs_done = done_vec(m2, d2, k2 - c, o - c);
      else cs_done = 3'($urandom);
    end
    cs_start = 1'b0; cs_cont = 1'b0; cs_done = 3'b000;
  endtask

  task automatic hs_reset_case();
    hs_en = 3'b111; hs_start = 1'b1; hs_done = 3'b000;
    for (int o = 1; o <= 10; o++) begin
      tick();
      if (o == 1) chk("hsr_ch_start", hs_chs, 3'b111);
      if (o == 4) begin
        chk("hsr_idle", hs_idle, 1'b1);
        chk("hsr_done", hs_apdone, 1'b0);
        chk("hsr_ready", hs_ready, 1'b0);
        chk("hsr_ch_start0", hs_chs, 3'b000);
        chk("hsr_busy", hs_busy, 0);
      end
      if (o > 4) begin
        chk("hsr_no_done", hs_apdone, 1'b0);
        chk("hsr_still_idle", hs_idle, 1'b1);
      end
      hs_start = 1'b0;
      hs_rst   = (o == 3);
      hs_done  = (o == 2) ? 3'b001 : ((o >= 4) ? 3'b111 : 3'b000);
    end
    hs_done = 3'b000;
  endtask

  task automatic cs_reset_case();
    cs_en = 3'b011; cs_start = 1'b1; cs_done = 3'b000; cs_cont = 1'b0;
    for (int o = 1; o <= 11; o++) begin
      tick();
      if (o == 1) chk("csr_ch_start", cs_chs, 3'b011);
      if (o == 6) chk("csr_hold_done", cs_apdone, 1'b1);
      if (o == 7) begin
        chk("csr_idle", cs_idle, 1'b1);
        chk("csr_done", cs_apdone, 1'b0);
        chk("csr_ready", cs_ready, 1'b0);
        chk("csr_busy", cs_busy, 0);
      end
      if (o >= 8) begin
        chk("csr_no_relaunch", cs_chs, 3'b000);
        chk("csr_still_idle", cs_idle, 1'b1);
        chk("csr_no_done", cs_apdone, 1'b0);
      end
      cs_start = (o == 2);
      cs_done  = (o == 4) ? 3'b011 : 3'b000;
      cs_rst   = (o == 6);
      cs_cont  = (o >= 7 && o <= 10);
    end
    cs_cont = 1'b0;
  endtask

  initial begin
    dly_t d, d2;
    logic [2:0] m, m2;
    int s2;
    hs_rst = 1'b1; hs_start = 1'b0; hs_cont = 1'b0; hs_en = 3'b000; hs_done = 3'b000;
    cs_rst = 1'b1; cs_start = 1'b0; cs_cont = 1'b0; cs_en = 3'b000; cs_done = 3'b000;
    tick();
    tick();
    chk("rst_hs_idle", hs_idle, 1'b1);
    chk("rst_hs_done", hs_apdone, 1'b0);
    chk("rst_hs_ready", hs_ready, 1'b0);
    chk("rst_hs_ch_start", hs_chs, 3'b000);
    chk("rst_hs_busy", hs_busy, 0);
    chk("rst_cs_idle", cs_idle, 1'b1);
    chk("rst_cs_done", cs_apdone, 1'b0);
    chk("rst_cs_busy", cs_busy, 0);
    hs_rst = 1'b0; cs_rst = 1'b0;
    tick();

    hs_task(3'b111, '{5, 12, 9}, 1'b0);
    hs_task(3'b101, '{4, 2, 7}, 1'b1);
    hs_task(3'b000, '{1, 1, 1}, 1'b0);
    hs_reset_case();
    hs_task(3'b001, '{300, 1, 1}, 1'b0);
    for (int n = 0; n < 20; n++) begin
      m = 3'($urandom);
      for (int i = 0; i < 3; i++) d[i] = $urandom_range(1, 15);
      hs_task(m, d, 1'($urandom));
    end

    cs_task(3'b111, '{5, 9, 7}, 4, 1, 3'b011, '{4, 6, 1}, 1'b1);
    cs_task(3'b010, '{1, 6, 1}, 2, 2, 3'b101, '{5, 1, 8}, 1'b0);
    cs_task(3'b110, '{1, 4, 5}, 0, 0, 3'b111, '{4, 4, 4}, 1'b0);
    cs_reset_case();
    for (int n = 0; n < 10; n++) begin
      m  = 3'($urandom_range(1, 7));
      m2 = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) begin
        d[i]  = $urandom_range(4, 12);
        d2[i] = $urandom_range(4, 12);
      end
      s2 = $urandom_range(0, 2);
      cs_task(m, d, $urandom_range(0, 5), s2, m2, d2, (s2 == 1) && 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kvadd_kernel_ctrl.md
# kvadd_kernel_ctrl

Parametrised kernel control sequencer that replaces the hard-wired ap_start/ap_idle/ap_done logic of the top-level kvadd kernel. It fans a start out to NUM_CH channel engines (one per m_axi port) and aggregates their done pulses under a runtime channel-enable mask. It supports both ap_ctrl_hs and ap_ctrl_chain handshakes, including a one-deep queued start in chain mode, and exports a run-time cycle counter. It sits between the host control-register block and the per-port vadd engines.

## Interface
- NUM_CH, default 3: number of channel engines; legal range 1..16.
- CTRL_MODE, default 0: 0 = ap_ctrl_hs, 1 = ap_ctrl_chain.
- CNT_W, default 32: width of busy_cycles; legal range 8..64.
- ap_clk  in  1  kernel clock; single clock domain.
- areset  in  1  synchronous, active-high reset.
- ap_start  in  1  host start; a start event is a rising edge (ap_start & ~ap_start_r).
- ap_continue  in  1  chain-mode acknowledge of ap_done; ignored when CTRL_MODE=0.
- ch_enable  in  NUM_CH  channel mask, sampled only on an accepted start.
- ch_done  in  NUM_CH  per-channel one-cycle done pulses from the engines.
- ap_idle  out  1  high when no task is running or held.
- ap_done  out  1  task completion.
- ap_ready  out  1  task accepted / input consumed.
- ch_start  out  NUM_CH  one-cycle start pulse to each enabled channel.
- busy_cycles  out  CNT_W  number of cycles spent in RUN during the most recent task.

## Operation
- States: IDLE, RUN, HOLD. HOLD is reachable only when CTRL_MODE=1.
- Reset values: state=IDLE, ap_start_r=0, ap_idle=1, ap_done=0, ap_ready=0, ch_start=0, mask_r=0, done_r=0, pend=0, busy_cycles=0.
- IDLE:
  - On a start event: mask_r<=ch_enable, done_r<=0, busy_cycles<=0, then go to RUN.
- RUN:
  - ch_start = mask_r during the first RUN cycle only.
  - done_r <= done_r | (ch_done & mask_r). ch_done bits outside mask_r are ignored. Repeated pulses are idempotent. ch_done is ignored outside RUN.
  - busy_cycles increments each RUN cycle and saturates at all-ones.
  - Completion condition: done_r == mask_r.
  - HS mode, on completion: ap_done=1 and ap_ready=1 for exactly one cycle, then go to IDLE.
  - Chain mode, on completion: ap_ready=1 for one cycle, then go to HOLD.
- HOLD (chain mode only):
  - ap_done is held at 1.
  - When ap_continue=1: ap_done drops next cycle. If pend=1, clear pend, reload mask_r from ch_enable at that cycle, clear done_r and busy_cycles, and go to RUN. Otherwise go to IDLE.
- Start events seen in RUN or HOLD:
  - Chain mode: set pend; a second event while pend=1 is dropped.
  - HS mode: dropped.
- Empty mask (ch_enable=0): completion holds in the first RUN cycle and no ch_start is issued.
- busy_cycles holds its value after completion until the next accepted start.

## Timing
- Start rising edge sampled at edge t: RUN in cycle t+1, ch_start high in cycle t+1 only.
- Last required ch_done high in cycle k: done_r complete at k+1.
  - HS mode: ap_done/ap_ready high in k+1, ap_idle=1 from k+2.
  - Chain mode: ap_ready high in k+1, ap_done high from k+2.
- ap_idle is registered: it is 0 in every cycle where state != IDLE.
- ap_continue and a new start edge in the same HOLD cycle: the start sets pend and is launched by that continue.
- A ch_done arriving in the same cycle as ch_start is accepted.
- areset asserted mid-RUN or mid-HOLD: next cycle all outputs are at their reset values; the pending start and any partial done_r are discarded.
- No combinational path from any input to any output.

## Structure
- Package kvadd_ctrl_pkg holds:
  - enum ctrl_state_t {IDLE, RUN, HOLD}
  - localparams MODE_HS=0 and MODE_CHAIN=1
  - the mask-width function for NUM_CH
- Sub-module kvadd_sat_counter: CNT_W-bit counter with clear, enable and saturation, used for busy_cycles.
- The top level instantiates this block once in place of its local ap_* logic.

## Test plan
- HS mode, NUM_CH=3, ch_enable=3'b111, dones at t+5 (ch0), t+9 (ch2), t+12 (ch1) -> ch_start=3'b111 at t+1; ap_done/ap_ready single pulse at t+13; busy_cycles=12; ap_idle=1 at t+14.
- HS mode, ch_enable=3'b101, ch_done[1] pulsed plus ch0/ch2 done -> ch1 ignored; ch_start=3'b101; completion one cycle after the later of ch0/ch2.
- ch_enable=0 -> no ch_start; ap_done at t+1; busy_cycles=1.
- Chain mode, second start edge during RUN, ap_continue asserted 4 cycles after ap_done rises -> ap_done high for 5 cycles (k+2..k+6, one cycle past the continue); RUN re-entered with no IDLE cycle and ch_start pulses again; a third start edge during the same RUN is dropped.
- areset asserted two cycles after ch_start with dones outstanding -> all outputs at reset values next cycle; later ch_done pulses produce no ap_done.
- busy_cycles saturation with CNT_W=8 and a done 300 cycles after start -> busy_cycles=255.
